companion_stat_bank: RTL and testbench

- Parametrised successor to the single companion stat register.
- Holds NUM_STATS independent companion stats (hunger, energy, fun, ...) in one fully synchronous block. No gated clocks.
- Every stat decays on a global tick and is refilled through a valid/ready refresh channel.
- A health FSM watches all stats and drives the companion's ALIVE/WARNING/FAINTED status for the display/UI logic.

---
 rtl/companion_pkg.sv | 27 ++
 rtl/companion_stat_channel.sv | 57 +++++
 rtl/companion_stat_bank.sv | 140 ++++++++++++++
 tb/tb_companion_stat_bank.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/companion_pkg.sv
// Shared types and helpers for the companion stat bank: health status
// encoding, refresh-select width and the clamp used by every stat channel.
package companion_pkg;

  typedef enum logic [1:0] {
    STAT_ALIVE   = 2'd0,
    STAT_WARNING = 2'd1,
    STAT_FAINTED = 2'd2
  } status_e;

  // Select bus width; a single channel still gets a 1-bit select.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Saturate a signed add/sub result into [0, max_v].
  function automatic int sat_clamp(input int x, input int max_v);
    if (x < 0) begin
      return 0;
    end
    if (x > max_v) begin
      return max_v;
    end
    return x;
  endfunction

endpackage

// File: rtl/companion_stat_channel.sv
// One companion stat: clamped up/down counter with a registered low flag.
// A load (revive) overrides the increment/decrement path.
module companion_stat_channel
  import companion_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned MAX_VALUE      = 10,
  parameter int unsigned REFRESH_AMOUNT = 2,
  parameter int unsigned DECAY_AMOUNT   = 1,
  parameter int unsigned LOW_THRESHOLD  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  output logic [WIDTH-1:0] o_value,
  output logic             o_low,
  output logic             o_low_next_c
);

  localparam int unsigned SUM_W = WIDTH + 2;

  logic signed [SUM_W-1:0] w_sum;
  logic [WIDTH-1:0]        w_next;
  logic [WIDTH-1:0]        r_value;
  logic                    r_low;

  // Refresh and decay may land together; both apply before clamping.
  always_comb begin
    w_sum = $signed({2'b00, r_value});
    if (i_inc) begin
      w_sum = w_sum + $signed(SUM_W'(REFRESH_AMOUNT));
    end
    if (i_dec) begin
      w_sum = w_sum - $signed(SUM_W'(DECAY_AMOUNT));
    end
    w_next = i_load ? i_load_value : WIDTH'(sat_clamp(int'(w_sum), int'(MAX_VALUE)));
  end

  assign o_low_next_c = (w_next <= WIDTH'(LOW_THRESHOLD));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_value <= WIDTH'(MAX_VALUE);
      r_low   <= 1'b0;
    end else begin
      r_value <= w_next;
      r_low   <= o_low_next_c;
    end
  end

  assign o_value = r_value;
  assign o_low   = r_low;

endmodule

// File: rtl/companion_stat_bank.sv
// Bank of NUM_STATS decaying companion stats with refresh channel and health FSM.
// Optional tick prescaler enabled by defining COMPANION_STAT_PRESCALE_EN.
module companion_stat_bank
  import companion_pkg::*;
#(
  parameter int unsigned NUM_STATS      = 4,
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned MAX_VALUE      = 10,
  parameter int unsigned REFRESH_AMOUNT = 2,
  parameter int unsigned DECAY_AMOUNT   = 1,
  parameter int unsigned LOW_THRESHOLD  = 3,
  parameter int unsigned FAINT_TICKS    = 4,
  parameter int unsigned TICK_DIV       = 4,
  localparam int unsigned SEL_W         = sel_width(NUM_STATS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic                       refresh_valid,
  input  logic [SEL_W-1:0]           refresh_sel,
  output logic                       refresh_ready,
  input  logic                       revive,
  output logic [NUM_STATS*WIDTH-1:0] values,
  output logic [NUM_STATS-1:0]       low,
  output logic [1:0]                 status
);

  localparam int unsigned CNT_W = $clog2(FAINT_TICKS + 1);
  localparam logic [WIDTH-1:0] REVIVE_VALUE = WIDTH'(MAX_VALUE / 2);

  if (NUM_STATS == 0 || TICK_DIV == 0 || 64'(MAX_VALUE) >= (64'(1) << WIDTH)) begin : g_param_check
    $error("companion_stat_bank: illegal parameter set");
  end

  status_e              r_status;
  status_e              w_status_next;
  logic [CNT_W-1:0]     r_faint_cnt;
  logic [CNT_W-1:0]     w_faint_next;
  logic                 w_fainted;
  logic                 w_accept;
  logic                 w_eff_tick;
  logic                 w_any_zero;
  logic                 w_revive_load;
  logic [NUM_STATS-1:0] w_low_next;

  assign w_fainted     = (r_status == STAT_FAINTED);
  assign refresh_ready = !w_fainted;
  assign w_accept      = refresh_valid && refresh_ready;
  assign w_revive_load = w_fainted && revive;
  assign status        = r_status;

`ifdef COMPANION_STAT_PRESCALE_EN
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0] r_presc;
  logic             w_presc_wrap;

  // Only every TICK_DIV-th tick pulse decays the stats; parked while fainted.
  assign w_presc_wrap = (r_presc == PRE_W'(TICK_DIV - 1));
  assign w_eff_tick   = tick && w_presc_wrap && !w_fainted;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (w_fainted) begin
      r_presc <= '0;
    end else if (tick) begin
      r_presc <= w_presc_wrap ? '0 : r_presc + PRE_W'(1);
    end
  end
`else
  assign w_eff_tick = tick && !w_fainted;
`endif

  for (genvar gi = 0; gi < NUM_STATS; gi++) begin : g_chan
    companion_stat_channel #(
      .WIDTH          (WIDTH),
      .MAX_VALUE      (MAX_VALUE),
      .REFRESH_AMOUNT (REFRESH_AMOUNT),
      .DECAY_AMOUNT   (DECAY_AMOUNT),
      .LOW_THRESHOLD  (LOW_THRESHOLD)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .i_inc        (w_accept && (refresh_sel == SEL_W'(gi))),
      .i_dec        (w_eff_tick),
      .i_load       (w_revive_load),
      .i_load_value (REVIVE_VALUE),
      .o_value      (values[gi*WIDTH +: WIDTH]),
      .o_low        (low[gi]),
      .o_low_next_c (w_low_next[gi])
    );
  end

  always_comb begin
    w_any_zero = 1'b0;
    for (int i = 0; i < int'(NUM_STATS); i++) begin
      if (values[i*WIDTH +: WIDTH] == '0) begin
        w_any_zero = 1'b1;
      end
    end
  end

  // Status follows the next-cycle low bits so it moves together with values.
  always_comb begin
    w_status_next = r_status;
    w_faint_next  = r_faint_cnt;
    case (r_status)
      STAT_FAINTED: begin
        if (revive) begin
          w_faint_next  = '0;
          w_status_next = (|w_low_next) ? STAT_WARNING : STAT_ALIVE;
        end
      end
      default: begin
        if (!w_any_zero) begin
          w_faint_next = '0;
        end else if (w_eff_tick && (r_faint_cnt < CNT_W'(FAINT_TICKS))) begin
          w_faint_next = r_faint_cnt + CNT_W'(1);
        end
        if (r_faint_cnt == CNT_W'(FAINT_TICKS)) begin
          w_status_next = STAT_FAINTED;
        end else begin
          w_status_next = (|w_low_next) ? STAT_WARNING : STAT_ALIVE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_status    <= STAT_ALIVE;
      r_faint_cnt <= '0;
    end else begin
      r_status    <= w_status_next;
      r_faint_cnt <= w_faint_next;
    end
  end

endmodule

// File: tb/tb_companion_stat_bank.sv
// Self-checking bench for companion_stat_bank: directed scenarios then random
// traffic, all compared against an integer reference model of the stat rules.
module tb_companion_stat_bank;

  localparam int NUM  = 5;
  localparam int W    = 8;
  localparam int MAXV = 10;
  localparam int REF  = 2;
  localparam int DEC  = 1;
  localparam int LOWT = 3;
  localparam int FT   = 4;
  localparam int TD   = 4;
  localparam int SW   = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           tick;
  logic           refresh_valid;
  logic [SW-1:0]  refresh_sel;
  logic           refresh_ready;
  logic           revive;
  logic [NUM*W-1:0] values;
  logic [NUM-1:0] low;
  logic [1:0]     status;

  int n_vec = 0;
  int n_err = 0;

  int m_val [NUM];
  int m_status;
  int m_cnt;
  int m_presc;

  companion_stat_bank #(
    .NUM_STATS      (NUM),
    .WIDTH          (W),
    .MAX_VALUE      (MAXV),
    .REFRESH_AMOUNT (REF),
    .DECAY_AMOUNT   (DEC),
    .LOW_THRESHOLD  (LOWT),
    .FAINT_TICKS    (FT),
    .TICK_DIV       (TD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .refresh_valid (refresh_valid),
    .refresh_sel   (refresh_sel),
    .refresh_ready (refresh_ready),
    .revive        (revive),
    .values        (values),
    .low           (low),
    .status        (status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM; i++) m_val[i] = MAXV;
    m_status = 0;
    m_cnt    = 0;
    m_presc  = 0;
  endtask

  // Reference behaviour for one clock edge, computed from the pre-edge state.
  task automatic model_update(input bit t, input bit v, input int s, input bit rv);
    bit fainted;
    bit eff;
    bit any_zero;
    bit any_low;
    bit fainting;
    int nv;
    fainted = (m_status == 2);
    eff     = t && !fainted;
`ifdef COMPANION_STAT_PRESCALE_EN
    eff = 1'b0;
    if (fainted) m_presc = 0;
    else if (t) begin
      eff     = (m_presc == TD - 1);
      m_presc = (m_presc + 1) % TD;
    end
`endif
    any_zero = 1'b0;
    for (int i = 0; i < NUM; i++) if (m_val[i] == 0) any_zero = 1'b1;
    if (fainted) begin
      if (rv) begin
        for (int i = 0; i < NUM; i++) m_val[i] = MAXV / 2;
        m_cnt    = 0;
        m_status = ((MAXV / 2) <= LOWT) ? 1 : 0;
      end
    end else begin
      fainting = (m_cnt == FT);
      any_low  = 1'b0;
      for (int i = 0; i < NUM; i++) begin
        nv = m_val[i];
        if (v && s == i) nv = nv + REF;
        if (eff) nv = nv - DEC;
        if (nv < 0) nv = 0;
        if (nv > MAXV) nv = MAXV;
        m_val[i] = nv;
        if (nv <= LOWT) any_low = 1'b1;
      end
      if (!any_zero) m_cnt = 0;
      else if (eff && m_cnt < FT) m_cnt = m_cnt + 1;
      m_status = fainting ? 2 : (any_low ? 1 : 0);
    end
  endtask

  task automatic check_state(input string tag);
    logic [NUM*W-1:0] ev;
    logic [NUM-1:0]   el;
    for (int i = 0; i < NUM; i++) begin
      ev[i*W +: W] = W'(m_val[i]);
      el[i]        = (m_val[i] <= LOWT);
    end
    check({tag, ".values"}, 64'(values), 64'(ev));
    check({tag, ".low"}, 64'(low), 64'(el));
    check({tag, ".status"}, 64'(status), 64'(m_status));
  endtask

  task automatic step(input string tag, input bit t, input bit v, input int s, input bit rv);
    @(negedge clk);
    tick          = t;
    refresh_valid = v;
    refresh_sel   = SW'(s);
    revive        = rv;
    #1 check({tag, ".ready"}, 64'(refresh_ready), 64'(m_status != 2));
    @(posedge clk);
    model_update(t, v, s, rv);
    #1 check_state(tag);
  endtask

  initial begin
    logic [NUM*W-1:0] all_max;
    logic [NUM*W-1:0] all_half;
    all_max  = {NUM{8'(MAXV)}};
    all_half = {NUM{8'(MAXV / 2)}};

    rst           = 1'b0;
    tick          = 1'b0;
    refresh_valid = 1'b0;
    refresh_sel   = '0;
    revive        = 1'b0;
    model_reset();
    #12;
    check_state("reset");
    check("reset.values_max", 64'(values), 64'(all_max));
    check("reset.ready", 64'(refresh_ready), 64'(1));
    @(negedge clk);
    rst = 1'b1;

    // Decay every channel down to the floor and past it.
    for (int k = 1; k <= 12; k++) begin
      step("decay", 1'b1, 1'b0, 0, 1'b0);
`ifndef COMPANION_STAT_PRESCALE_EN
      if (k == 7) begin
        check("decay7.ch0", 64'(values[7:0]), 64'(3));
        check("decay7.status", 64'(status), 64'(1));
      end
`endif
    end
`ifndef COMPANION_STAT_PRESCALE_EN
    check("floor.values", 64'(values), 64'(0));
    check("floor.low", 64'(low), 64'({NUM{1'b1}}));
`endif

    step("sel_oor", 1'b0, 1'b1, 5, 1'b0);
    for (int k = 0; k < 6; k++) step("refresh_ch2", 1'b0, 1'b1, 2, 1'b0);
    check("ceiling.ch2", 64'(values[2*W +: W]), 64'(MAXV));
    step("tick_only", 1'b1, 1'b0, 0, 1'b0);
    step("tick_refresh", 1'b1, 1'b1, 2, 1'b0);
`ifndef COMPANION_STAT_PRESCALE_EN
    check("tick_refresh.ch2", 64'(values[2*W +: W]), 64'(MAXV));
`endif
    step("to_faint", 1'b0, 1'b0, 0, 1'b0);
`ifndef COMPANION_STAT_PRESCALE_EN
    check("faint.status", 64'(status), 64'(2));
    check("faint.ready", 64'(refresh_ready), 64'(0));
`endif
    for (int k = 0; k < 4; k++) step("frozen", 1'b1, 1'b1, int'($urandom_range(NUM - 1, 0)), 1'b0);

    step("revive", 1'b0, 1'b0, 0, 1'b1);
`ifndef COMPANION_STAT_PRESCALE_EN
    check("revive.values", 64'(values), 64'(all_half));
    check("revive.status", 64'(status), 64'(0));
    check("revive.ready", 64'(refresh_ready), 64'(1));
`endif
    step("warn", 1'b1, 1'b0, 0, 1'b0);
    step("warn", 1'b1, 1'b0, 0, 1'b0);

    // Asynchronous reset asserted between clock edges.
    @(posedge clk);
    #2 tick = 1'b1;
    #1 rst = 1'b0;
    #1;
    model_reset();
    check_state("async_rst");
    check("async_rst.values_max", 64'(values), 64'(all_max));
    @(negedge clk);
    tick = 1'b0;
    rst  = 1'b1;

`ifdef COMPANION_STAT_PRESCALE_EN
    for (int k = 0; k < 8; k++) step("prescale", 1'b1, 1'b0, 0, 1'b0);
    check("prescale.ch0", 64'(values[7:0]), 64'(MAXV - 2));
`endif

    for (int k = 0; k < 400; k++) begin
      step("random",
           $urandom_range(3, 0) != 0,
           $urandom_range(2, 0) == 0,
           int'($urandom_range(7, 0)),
           $urandom_range(15, 0) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
